// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multi-cycle MIPS datapath.
// Outputs decode the current state; IRWrite/PCWrite in FETCH also follow mem_ready.
module multicycle_controller #(
  parameter int              OPW      = 6,
  parameter logic [OPW-1:0]  JR_FUNCT = 6'b001000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] Opcode,
  input  logic [OPW-1:0] Funct,
  input  logic           mem_ready,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IorD,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           Branch_eq,
  output logic           Branch_ne,
  output logic           RegWrite,
  output logic           RegDest,
  output logic           MemToReg,
  output logic           JAL,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JALST  = 4'd11,
    JRST   = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);

  state_t         cur, nxt;
  logic [OPW-1:0] op_q, fn_q;

  assign state = cur;

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:   nxt = MEMADR;
          OP_RTYPE:       nxt = (Funct == JR_FUNCT) ? JRST : EXEC;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:        nxt = ADDIEX;
          OP_JAL:         nxt = JALST;
          default:        nxt = FETCH;
        endcase
      end
      MEMADR: nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) nxt = MEMWB;
      MEMWB:  nxt = FETCH;
      MEMWR:  if (mem_ready) nxt = FETCH;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur  <= FETCH;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) begin
        op_q <= Opcode;
        fn_q <= Funct;
      end
    end
  end

  // Gated by reset_n so strobes drop the moment reset asserts, not at the next edge.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch_eq = 1'b0;
    Branch_ne = 1'b0;
    RegWrite  = 1'b0;
    RegDest   = 1'b0;
    MemToReg  = 1'b0;
    JAL       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = '0;
    ALUOp     = '0;
    PCSrc     = '0;
    if (reset_n) begin
      case (cur)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDest  = 1'b1;
        end
        BRANCH: begin
          ALUSrcA   = 1'b1;
          ALUOp     = 2'b01;
          PCSrc     = 2'b01;
          Branch_eq = (op_q == OP_BEQ);
          Branch_ne = (op_q == OP_BNE);
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB: RegWrite = 1'b1;
        JALST: begin
          PCWrite  = 1'b1;
          PCSrc    = 2'b10;
          RegWrite = 1'b1;
          JAL      = 1'b1;
        end
        JRST: begin
          // Latched funct re-qualifies the jump; JRST is only reachable with a JR funct.
          PCWrite = (fn_q == JR_FUNCT);
          PCSrc   = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against an instruction-path model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Opcode, Funct;
  logic       mem_ready;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch_eq, Branch_ne;
  logic       RegWrite, RegDest, MemToReg, JAL, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller #(.OPW(6), .JR_FUNCT(6'b001000)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch_eq(Branch_eq), .Branch_ne(Branch_ne), .RegWrite(RegWrite), .RegDest(RegDest),
    .MemToReg(MemToReg), .JAL(JAL), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Model: the instruction's state path, position in it, and its opcode.
  int         m_path[$];
  int         m_pos;
  logic [5:0] m_op;
  bit         m_rst = 1'b1;
  bit         chk_en = 1'b0;
  int         exp_state = 0;

  int seq_log[$];
  int exp_seq[$];
  int cnt_irw, cnt_mw, cnt_rw, rw_state;
  logic [1:0] br_seen;

  logic [17:0] dut_vec;
  assign dut_vec = {MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch_eq, Branch_ne, RegWrite,
                    RegDest, MemToReg, JAL, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  function automatic logic [17:0] model_out(int st, logic [5:0] op, logic mr, bit rst);
    logic mrd = 0, mwr = 0, iord = 0, irw = 0, pcw = 0, beq = 0, bne = 0, rw = 0;
    logic rd = 0, m2r = 0, jal = 0, sa = 0;
    logic [1:0] sb = 0, aop = 0, pcs = 0;
    if (!rst) begin
      case (st)
        0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
        1:  sb = 2'b11;
        2:  begin sa = 1; sb = 2'b10; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin rw = 1; m2r = 1; end
        5:  begin mwr = 1; iord = 1; end
        6:  begin sa = 1; aop = 2'b10; end
        7:  begin rw = 1; rd = 1; end
        8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; beq = (op == 6'b000100); bne = (op == 6'b000101); end
        9:  begin sa = 1; sb = 2'b10; end
        10: rw = 1;
        11: begin pcw = 1; pcs = 2'b10; rw = 1; jal = 1; end
        12: begin pcw = 1; pcs = 2'b11; end
        default: ;
      endcase
    end
    return {mrd, mwr, iord, irw, pcw, beq, bne, rw, rd, m2r, jal, sa, sb, aop, pcs};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [17:0] e;
      e = model_out(exp_state, m_op, mem_ready, m_rst);
      checks++;
      if (state !== 4'(exp_state)) begin
        errors++;
        $display("FAIL state: got %0d expected %0d", state, exp_state);
      end
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL outputs (state %0d): got %b expected %b", exp_state, dut_vec, e);
      end
      seq_log.push_back(int'(state));
      if (IRWrite) cnt_irw++;
      if (MemWrite) cnt_mw++;
      if (RegWrite) begin cnt_rw++; rw_state = int'(state); end
      if (state == 4'd8) br_seen = {Branch_eq, Branch_ne};
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic check_seq(input string name);
    bit bad;
    bad = (seq_log.size() != exp_seq.size());
    if (!bad)
      foreach (exp_seq[i]) if (seq_log[i] != exp_seq[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got %p expected %p", name, seq_log, exp_seq);
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input bit rnd,
                          input int fw, input int mw, input int abort_st);
    bit done;
    int fwc, mwc;
    m_path = {0, 1};
    case (op)
      6'b100011: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
      6'b101011: begin m_path.push_back(2); m_path.push_back(5); end
      6'b000000: if (fn == 6'b001000) m_path.push_back(12);
                 else begin m_path.push_back(6); m_path.push_back(7); end
      6'b000100, 6'b000101: m_path.push_back(8);
      6'b001000: begin m_path.push_back(9); m_path.push_back(10); end
      6'b000011: m_path.push_back(11);
      default: ;
    endcase
    m_op = op; m_pos = 0; done = 0; fwc = 0; mwc = 0;
    Opcode = op; Funct = fn;
    seq_log.delete(); cnt_irw = 0; cnt_mw = 0; cnt_rw = 0; rw_state = -1; br_seen = 2'b00;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      int st;
      st = m_path[m_pos];
      if (m_pos >= 2 && rnd) begin Opcode = 6'($urandom); Funct = 6'($urandom); end
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
      else if (st == 0 && fwc < fw) begin mem_ready = 0; fwc++; end
      else if ((st == 3 || st == 5) && mwc < mw) begin mem_ready = 0; mwc++; end
      else mem_ready = 1;
      exp_state = st;
      if (st == abort_st) begin
        @(negedge clk);
        #2;
        reset_n = 0; m_rst = 1; exp_state = 0;
        #1;
        chk("abort_memwrite", int'(MemWrite), 0);
        chk("abort_state", int'(state), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1; m_rst = 0;
        return;
      end
      @(posedge clk);
      if (!(st == 0 || st == 3 || st == 5) || mem_ready) m_pos++;
      if (m_pos == m_path.size()) done = 1;
      #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: instruction %b did not complete", op);
    end
  endtask

  initial begin
    reset_n = 0; mem_ready = 1; Opcode = 6'b000000; Funct = 6'b100000;
    m_op = 6'b000000; m_rst = 1; exp_state = 0; chk_en = 1;
    cnt_irw = 0; cnt_mw = 0; cnt_rw = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", cnt_irw + cnt_mw + cnt_rw, 0);
    reset_n = 1; m_rst = 0;

    do_instr(6'b000000, 6'b100000, 0, 0, 0, -1);
    exp_seq = {0, 1, 6, 7}; check_seq("seq_rtype");
    chk("rtype_end", int'(state), 0);
    chk("rtype_rw_cnt", cnt_rw, 1);
    chk("rtype_rw_state", rw_state, 7);

    do_instr(6'b100011, 6'b000000, 0, 2, 1, -1);
    exp_seq = {0, 0, 0, 1, 2, 3, 3, 4}; check_seq("seq_lw_wait");
    chk("lw_end", int'(state), 0);
    chk("lw_irwrite_cnt", cnt_irw, 1);
    chk("lw_rw_state", rw_state, 4);

    do_instr(6'b101011, 6'b000000, 0, 0, 0, -1);
    exp_seq = {0, 1, 2, 5}; check_seq("seq_sw");
    chk("sw_memwrite_cnt", cnt_mw, 1);
    chk("sw_rw_cnt", cnt_rw, 0);

    do_instr(6'b000100, 6'b000000, 0, 0, 0, -1);
    exp_seq = {0, 1, 8}; check_seq("seq_beq");
    chk("beq_flags", int'(br_seen), 2);
    do_instr(6'b000101, 6'b000000, 0, 0, 0, -1);
    exp_seq = {0, 1, 8}; check_seq("seq_bne");
    chk("bne_flags", int'(br_seen), 1);

    do_instr(6'b000011, 6'b000000, 0, 0, 0, -1);
    exp_seq = {0, 1, 11}; check_seq("seq_jal");
    chk("jal_rw_state", rw_state, 11);
    do_instr(6'b000000, 6'b001000, 0, 0, 0, -1);
    exp_seq = {0, 1, 12}; check_seq("seq_jr");
    chk("jr_rw_cnt", cnt_rw, 0);

    do_instr(6'b111111, 6'b000000, 0, 0, 0, -1);
    exp_seq = {0, 1}; check_seq("seq_illegal");
    chk("illegal_writes", cnt_rw + cnt_mw, 0);

    do_instr(6'b101011, 6'b000000, 0, 0, 50, 5);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      case ($urandom_range(0, 8))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b000101;
        6: op = 6'b001000;
        7: op = 6'b000011;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      do_instr(op, fn, 1, 0, 0, -1);
    end

    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
